// File: rtl/fetch_t_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_t_pkg
// Description : Shared types and constants for the instruction fetch stage
//               and the decoder (opcode field positions, FSM states, length).
//               Optional feature macro: FETCH_RESET_VECTOR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_t_pkg;

    localparam int AAA_MSB = 7;
    localparam int AAA_LSB = 5;
    localparam int BBB_MSB = 4;
    localparam int BBB_LSB = 2;
    localparam int CC_MSB  = 1;
    localparam int CC_LSB  = 0;

    localparam logic [15:0] RESET_VEC_ADDR = 16'hFFFC;

    // Instruction length in bytes, legal values 1..3
    typedef logic [1:0] instr_len_t;

    typedef enum logic [2:0] {
        S_OPC = 3'd0,
        S_LO  = 3'd1,
        S_HI  = 3'd2,
        S_OUT = 3'd3
`ifdef FETCH_RESET_VECTOR_EN
        ,
        S_VLO = 3'd4,
        S_VHI = 3'd5
`endif
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_t_instr_len_decode.sv
`default_nettype none
// ============================================================================
// Module      : instr_len_decode_t
// Description : Combinational opcode to instruction-length (1..3 bytes) decode.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_len_decode_t
    import fetch_t_pkg::*;
(
    input  logic [7:0] opcode_i,
    output instr_len_t len_o
);

    logic [2:0] w_aaa;
    logic [2:0] w_bbb;
    logic [1:0] w_cc;

    assign w_aaa = opcode_i[AAA_MSB:AAA_LSB];
    assign w_bbb = opcode_i[BBB_MSB:BBB_LSB];
    assign w_cc  = opcode_i[CC_MSB:CC_LSB];

    always_comb begin
        len_o = 2'd1;
        case (w_cc)
            2'b01: begin
                if (w_bbb == 3'b011 || w_bbb == 3'b110 || w_bbb == 3'b111)
                    len_o = 2'd3;
                else
                    len_o = 2'd2;
            end
            2'b10: begin
                if (w_bbb == 3'b011 || w_bbb == 3'b111)
                    len_o = 2'd3;
                else if (w_bbb == 3'b000 || w_bbb == 3'b001 || w_bbb == 3'b101)
                    len_o = 2'd2;
                else
                    len_o = 2'd1;
            end
            2'b00: begin
                if (w_bbb == 3'b000) begin
                    // JSR carries an absolute target; the other bbb=000 forms split 1/2
                    if (w_aaa == 3'b001)
                        len_o = 2'd3;
                    else if (w_aaa == 3'b000 || w_aaa == 3'b010 || w_aaa == 3'b011)
                        len_o = 2'd1;
                    else
                        len_o = 2'd2;
                end else if (w_bbb == 3'b011 || w_bbb == 3'b111) begin
                    len_o = 2'd3;
                end else if (w_bbb == 3'b001 || w_bbb == 3'b100 || w_bbb == 3'b101) begin
                    len_o = 2'd2;
                end else begin
                    len_o = 2'd1;
                end
            end
            default: len_o = 2'd1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/fetch_t.sv
`default_nettype none
// ============================================================================
// Module      : fetch_t
// Description : Instruction fetch stage: owns the PC, reads 1..3 byte
//               instructions from byte-wide memory and hands {opcode, operand}
//               downstream over valid/ready. Define FETCH_RESET_VECTOR_EN to
//               load the start PC from the reset vector at FFFC/FFFD.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_t
    import fetch_t_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h8000
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    output logic        mem_req_o,
    output logic [15:0] mem_addr_o,
    input  logic [7:0]  mem_rdata_i,
    output logic [7:0]  opcode_o,
    output logic [15:0] data_o,
    output logic [15:0] pc_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    input  logic        redirect_i,
    input  logic [15:0] redirect_pc_i
);

    fetch_state_t r_state;
    logic [15:0]  r_pc;
    logic         r_pending;
    instr_len_t   r_len;
    logic [7:0]   r_opcode;
    logic [15:0]  r_data;
    logic [15:0]  r_pc_out;
    logic         r_valid;

    instr_len_t   w_len;
    logic         w_redirect;
    logic [15:0]  w_addr;

    instr_len_decode_t u_len_decode (
        .opcode_i (mem_rdata_i),
        .len_o    (w_len)
    );

    // Redirects only act once the PC is architecturally owned (not during vector load)
    always_comb begin
        w_redirect = 1'b0;
        case (r_state)
            S_OPC, S_LO, S_HI, S_OUT: w_redirect = redirect_i;
            default:                  w_redirect = 1'b0;
        endcase
    end

    always_comb begin
        w_addr = r_pc;
        case (r_state)
            S_OPC:   w_addr = r_pc;
            S_LO:    w_addr = r_pc + 16'd1;
            S_HI:    w_addr = r_pc + 16'd2;
`ifdef FETCH_RESET_VECTOR_EN
            S_VLO:   w_addr = RESET_VEC_ADDR;
            S_VHI:   w_addr = RESET_VEC_ADDR + 16'd1;
`endif
            default: w_addr = r_pc;
        endcase
    end

    assign mem_req_o     = rstn_i && !r_pending && (r_state != S_OUT);
    assign mem_addr_o    = w_addr;
    assign opcode_o      = r_opcode;
    assign data_o        = r_data;
    assign pc_o          = r_pc_out;
    assign instr_valid_o = r_valid;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
`ifdef FETCH_RESET_VECTOR_EN
            r_state <= S_VLO;
`else
            r_state <= S_OPC;
`endif
            r_pc      <= RESET_PC;
            r_pending <= 1'b0;
            r_len     <= 2'd1;
            r_opcode  <= 8'h00;
            r_data    <= 16'h0000;
            r_pc_out  <= 16'h0000;
            r_valid   <= 1'b0;
        end else if (w_redirect) begin
            // Flush: any in-flight read data is dropped by clearing pending
            r_state   <= S_OPC;
            r_pc      <= redirect_pc_i;
            r_pending <= 1'b0;
            r_valid   <= 1'b0;
        end else begin
            case (r_state)
`ifdef FETCH_RESET_VECTOR_EN
                S_VLO: begin
                    if (!r_pending) begin
                        r_pending <= 1'b1;
                    end else begin
                        r_pending <= 1'b0;
                        r_pc[7:0] <= mem_rdata_i;
                        r_state   <= S_VHI;
                    end
                end
                S_VHI: begin
                    if (!r_pending) begin
                        r_pending <= 1'b1;
                    end else begin
                        r_pending  <= 1'b0;
                        r_pc[15:8] <= mem_rdata_i;
                        r_state    <= S_OPC;
                    end
                end
`endif
                S_OPC: begin
                    if (!r_pending) begin
                        r_pending <= 1'b1;
                    end else begin
                        r_pending <= 1'b0;
                        r_opcode  <= mem_rdata_i;
                        r_data    <= 16'h0000;
                        r_pc_out  <= r_pc;
                        r_len     <= w_len;
                        if (w_len == 2'd1) begin
                            r_state <= S_OUT;
                            r_valid <= 1'b1;
                        end else begin
                            r_state <= S_LO;
                        end
                    end
                end
                S_LO: begin
                    if (!r_pending) begin
                        r_pending <= 1'b1;
                    end else begin
                        r_pending   <= 1'b0;
                        r_data[7:0] <= mem_rdata_i;
                        if (r_len == 2'd2) begin
                            r_state <= S_OUT;
                            r_valid <= 1'b1;
                        end else begin
                            r_state <= S_HI;
                        end
                    end
                end
                S_HI: begin
                    if (!r_pending) begin
                        r_pending <= 1'b1;
                    end else begin
                        r_pending    <= 1'b0;
                        r_data[15:8] <= mem_rdata_i;
                        r_state      <= S_OUT;
                        r_valid      <= 1'b1;
                    end
                end
                S_OUT: begin
                    if (instr_ready_i) begin
                        r_valid <= 1'b0;
                        r_pc    <= r_pc + {14'd0, r_len};
                        r_state <= S_OPC;
                    end
                end
                default: begin
                    r_state   <= S_OPC;
                    r_pending <= 1'b0;
                    r_valid   <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_t.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_t
// Description : Directed self-checking bench for fetch_t with a byte memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_t;

    logic        clk;
    logic        rstn;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic [7:0]  opcode;
    logic [15:0] data;
    logic [15:0] pc;
    logic        valid;
    logic        ready;
    logic        redirect;
    logic [15:0] redirect_pc;

    logic [7:0]  mem [0:65535];

    int n_tests = 0;
    int n_fail  = 0;

    fetch_t #(.RESET_PC(16'h8000)) dut (
        .clk_i         (clk),
        .rstn_i        (rstn),
        .mem_req_o     (mem_req),
        .mem_addr_o    (mem_addr),
        .mem_rdata_i   (mem_rdata),
        .opcode_o      (opcode),
        .data_o        (data),
        .pc_o          (pc),
        .instr_valid_o (valid),
        .instr_ready_i (ready),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_req)
            mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Counts cycles until valid rises; a bound of 40 keeps the bench from hanging
    task automatic wait_valid(input string tag, input int exp_n);
        int n;
        n = 0;
        while (valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(tag, n, exp_n);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h80;
        mem[16'h8000] = 8'hA9; mem[16'h8001] = 8'h42;
        mem[16'h8002] = 8'h4C; mem[16'h8003] = 8'h34; mem[16'h8004] = 8'h12;
        mem[16'h8005] = 8'hEA;
        mem[16'h8006] = 8'hA9; mem[16'h8007] = 8'h77;
        mem[16'h8008] = 8'hA5; mem[16'h8009] = 8'h10;
        mem[16'hC000] = 8'hEA;
        mem[16'hFFFE] = 8'h4C; mem[16'hFFFF] = 8'hAA; mem[16'h0000] = 8'hBB;
        mem[16'h0001] = 8'hEA;
        mem_rdata   = 8'h00;
        rstn        = 1'b0;
        ready       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;

        // Reset state
        step(); step();
        chk("rst_req",    {31'd0, mem_req}, 32'd0);
        chk("rst_valid",  {31'd0, valid},   32'd0);
        chk("rst_opcode", {24'd0, opcode},  32'd0);
        chk("rst_data",   {16'd0, data},    32'd0);
        chk("rst_pc",     {16'd0, pc},      32'd0);

        rstn = 1'b1;
        #1;
`ifdef FETCH_RESET_VECTOR_EN
        chk("vec_lo_addr", {16'd0, mem_addr}, 32'h0000FFFC);
        step();
        chk("vec_cap_req", {31'd0, mem_req},  32'd0);
        step();
        chk("vec_hi_addr", {16'd0, mem_addr}, 32'h0000FFFD);
        step(); step();
`endif
        chk("first_req",  {31'd0, mem_req},  32'd1);
        chk("first_addr", {16'd0, mem_addr}, 32'h00008000);

        // 2-byte instruction A9 42
        wait_valid("lat_A9", 4);
        chk("A9_opcode", {24'd0, opcode}, 32'h000000A9);
        chk("A9_data",   {16'd0, data},   32'h00000042);
        chk("A9_pc",     {16'd0, pc},     32'h00008000);
        step();
        chk("A9_drop_valid", {31'd0, valid},   32'd0);
        chk("A9_next_addr",  {16'd0, mem_addr}, 32'h00008002);

        // 3-byte instruction 4C 34 12
        wait_valid("lat_4C", 6);
        chk("4C_opcode", {24'd0, opcode}, 32'h0000004C);
        chk("4C_data",   {16'd0, data},   32'h00001234);
        chk("4C_pc",     {16'd0, pc},     32'h00008002);
        step();
        chk("4C_next_addr", {16'd0, mem_addr}, 32'h00008005);

        // 1-byte instruction EA
        wait_valid("lat_EA", 2);
        chk("EA_opcode", {24'd0, opcode}, 32'h000000EA);
        chk("EA_data",   {16'd0, data},   32'h00000000);
        step();
        chk("EA_next_addr", {16'd0, mem_addr}, 32'h00008006);

        // Stall in the output state
        wait_valid("lat_stall", 4);
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_valid", {31'd0, valid},  32'd1);
            chk("stall_req",   {31'd0, mem_req}, 32'd0);
            chk("stall_data",  {16'd0, data},   32'h00000077);
        end
        ready = 1'b1;
        step();
        chk("stall_release_valid", {31'd0, valid},    32'd0);
        chk("stall_release_addr",  {16'd0, mem_addr}, 32'h00008008);

        // Redirect during the low-operand capture cycle
        step();
        step();
        chk("A5_lo_addr", {16'd0, mem_addr}, 32'h00008009);
        step();
        redirect = 1'b1; redirect_pc = 16'hC000;
        step();
        redirect = 1'b0;
        chk("redir_valid", {31'd0, valid},    32'd0);
        chk("redir_req",   {31'd0, mem_req},  32'd1);
        chk("redir_addr",  {16'd0, mem_addr}, 32'h0000C000);
        chk("redir_data",  {16'd0, data},     32'h00000000);
        wait_valid("lat_C000", 2);
        chk("C000_pc", {16'd0, pc}, 32'h0000C000);
        step();
        chk("C000_next_addr", {16'd0, mem_addr}, 32'h0000C001);

        // 3-byte instruction wrapping the address space
        redirect = 1'b1; redirect_pc = 16'hFFFE;
        step();
        redirect = 1'b0;
        chk("wrap_opc_addr", {16'd0, mem_addr}, 32'h0000FFFE);
        step(); step();
        chk("wrap_lo_addr",  {16'd0, mem_addr}, 32'h0000FFFF);
        step(); step();
        chk("wrap_hi_addr",  {16'd0, mem_addr}, 32'h00000000);
        step(); step();
        chk("wrap_valid",  {31'd0, valid},  32'd1);
        chk("wrap_opcode", {24'd0, opcode}, 32'h0000004C);
        chk("wrap_data",   {16'd0, data},   32'h0000BBAA);
        chk("wrap_pc",     {16'd0, pc},     32'h0000FFFE);
        step();
        chk("wrap_next_addr", {16'd0, mem_addr}, 32'h00000001);

        // Redirect beats a simultaneous handshake
        wait_valid("lat_0001", 2);
        redirect = 1'b1; redirect_pc = 16'h8000;
        step();
        redirect = 1'b0;
        chk("redir_hs_valid", {31'd0, valid},    32'd0);
        chk("redir_hs_addr",  {16'd0, mem_addr}, 32'h00008000);
        wait_valid("lat_again", 4);
        chk("again_opcode", {24'd0, opcode}, 32'h000000A9);

        // Reset in the middle of a fetch
        step(); step(); step();
        rstn = 1'b0;
        #1;
        chk("rst_mid_req_comb", {31'd0, mem_req}, 32'd0);
        step();
        chk("rst_mid_valid",  {31'd0, valid},  32'd0);
        chk("rst_mid_opcode", {24'd0, opcode}, 32'd0);
        chk("rst_mid_data",   {16'd0, data},   32'd0);
        rstn = 1'b1;
        #1;
`ifdef FETCH_RESET_VECTOR_EN
        chk("rst_mid_addr", {16'd0, mem_addr}, 32'h0000FFFC);
`else
        chk("rst_mid_addr", {16'd0, mem_addr}, 32'h00008000);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_t.md
# fetch_t

Instruction fetch stage sitting directly upstream of `decoder_t`. It reads the byte-wide program memory at the program counter and, from the opcode, determines the instruction length (1–3 bytes). It then fetches the operand bytes and presents `{opcode, 16-bit operand}` to the decoder through a valid/ready handshake. It owns the PC, including the reset-vector load and redirects from branch/jump resolution.

## Interface
- `RESET_PC`, default `16'h8000`: start PC used when the reset-vector fetch is compiled out.
- `clk_i` in 1: single clock, rising edge.
- `rstn_i` in 1: reset, synchronous, active-low.
- `mem_req_o` out 1: memory read request this cycle.
- `mem_addr_o` out 16: read address, valid when `mem_req_o`=1.
- `mem_rdata_i` in 8: read data, valid exactly 1 cycle after the request cycle.
- `opcode_o` out 8: fetched opcode; feeds decoder `opcode_i`.
- `data_o` out 16: operand `{hi,lo}`; unfetched bytes are 0; feeds decoder `data_i`.
- `pc_o` out 16: address of the opcode byte.
- `instr_valid_o` out 1: instruction bundle valid.
- `instr_ready_i` in 1: downstream accepts the bundle.
- `redirect_i` in 1: load a new PC and flush the current fetch.
- `redirect_pc_i` in 16: new PC.

## Operation
- States:
  - `S_VLO`, `S_VHI`: vector fetch, macro only.
  - `S_OPC`, `S_LO`, `S_HI`: byte fetch.
  - `S_OUT`: hold the bundle.
- Each byte fetch takes 2 cycles:
  - Issue cycle: `mem_req_o`=1, address driven, `pending` set.
  - Capture cycle: `mem_rdata_i` registered, `pending` cleared, state advances. `mem_req_o`=0.
- Addresses:
  - `S_OPC` reads PC.
  - `S_LO` reads PC+1.
  - `S_HI` reads PC+2.
  - All address arithmetic is mod 2^16 (`FFFF`+1 = `0000`).
- After the opcode is captured, the length L comes from opcode fields `aaa=[7:5]`, `bbb=[4:2]`, `cc=[1:0]`:
  - cc=01: bbb∈{011,110,111} gives L=3; otherwise L=2.
  - cc=10: bbb∈{011,111} gives L=3; bbb∈{000,001,101} gives L=2; otherwise L=1.
  - cc=00:
    - bbb=000: aaa=001 (JSR) gives L=3; aaa∈{000,010,011} gives L=1; otherwise L=2.
    - bbb∈{011,111} gives L=3.
    - bbb∈{001,100,101} gives L=2.
    - otherwise L=1.
  - cc=11: L=1.
- Transitions:
  - After `S_OPC`: L=1 goes to `S_OUT`; otherwise to `S_LO`.
  - After `S_LO`: L=2 goes to `S_OUT`; otherwise to `S_HI`.
  - After `S_HI`: go to `S_OUT`.
- Behaviour in `S_OUT`:
  - `instr_valid_o`=1; `opcode_o`/`data_o`/`pc_o` are stable and no memory requests are made.
  - On `instr_valid_o & instr_ready_i`: PC ← PC+L, go to `S_OPC`.
- Redirect in any of `S_OPC`, `S_LO`, `S_HI`, `S_OUT`:
  - PC ← `redirect_pc_i`, `pending` cleared, go to `S_OPC`.
  - The in-flight read's data is ignored.
  - Redirect beats the handshake in the same cycle: the bundle counts as consumed, and the next PC is `redirect_pc_i`.
- Redirect is ignored in `S_VLO`/`S_VHI`.

## Timing
- Reset values, applied on a clock edge with `rstn_i`=0:
  - `instr_valid_o`=0, `opcode_o`=0, `data_o`=0, `pc_o`=0, `pending`=0.
  - State is `S_VLO` with the macro, `S_OPC` with PC=`RESET_PC` without it.
- `mem_req_o` is forced to 0 while `rstn_i`=0.
- Reset mid-fetch discards all partial state.
- Latency from entering `S_OPC` to `instr_valid_o`=1 is 2·L cycles.
- Handshake-to-next-`S_OPC` is 1 cycle.
- Throughput is one instruction per 2·L+1 cycles with `instr_ready_i` held high.
- `instr_valid_o` drops in the cycle after a handshake or redirect; it is never reasserted for a flushed bundle.
- `opcode_o`, `data_o` and `pc_o` are registered, updated only in capture cycles, and held otherwise.

## Configuration
- `FETCH_RESET_VECTOR_EN` defined:
  - After reset, `S_VLO` reads `FFFC` and `S_VHI` reads `FFFD` (2 cycles each).
  - PC ← `{FFFD,FFFC}`, then go to `S_OPC`.
  - `RESET_PC` is unused.
- `FETCH_RESET_VECTOR_EN` undefined:
  - `S_VLO`/`S_VHI` do not exist; reset goes straight to `S_OPC` with PC=`RESET_PC`.

## Structure
- Shared package holds:
  - `fetch_state_t` enum.
  - `instr_len_t` (2-bit).
  - `RESET_VEC_ADDR`=`16'hFFFC`.
  - The `aaa`/`bbb`/`cc` field position constants also used by the decoder.
- One sub-module, `instr_len_decode_t`: combinational opcode → L, reused by future prefetch logic.
- The FSM, PC, `pending` and the output registers live in `fetch_t`.

## Test plan
- Macro on, memory `FFFC`=`00`, `FFFD`=`80`: address sequence `FFFC`, `FFFD`, then `8000`; `pc_o`=`8000` on the first valid.
- `A9 42` at `8000`, ready=1: valid 4 cycles after `S_OPC` with `opcode_o`=`A9`, `data_o`=`0042`; next request to `8002`.
- `4C 34 12` at `8002`, then `EA` at `8005`:
  - First bundle `data_o`=`1234`, L=3.
  - Then `opcode_o`=`EA`, `data_o`=`0000`, valid after 2 cycles, next PC `8006`.
- `instr_ready_i`=0 for 5 cycles in `S_OUT`: outputs stable, `mem_req_o`=0 throughout; ready=1 then gives exactly one handshake.
- `redirect_i` with `redirect_pc_i`=`C000` during the `S_LO` capture cycle:
  - Stale byte dropped, `instr_valid_o` stays 0.
  - Next request is `C000`.
- 3-byte opcode at `FFFE`: operand reads at `FFFF` and `0000`; the next opcode is read from `0001`.
